adder_share_ctrl: RTL
=====================

// Module: adder_share_ctrl
// PURPOSE
//  Shares one WIDTH-bit ripple-carry add/subtract datapath between NREQ requesters (ALU, PC-increment, address-gen).
//  Round-robin arbitration with valid/ready handshakes on request and response sides; one operation in flight.
//  Operands and result are registered. The adder is a single combinational instance between the two register stages.
// PARAMETERS
//  WIDTH  32  operand/result width in bits
//  NREQ   4   number of requesters (2..8)
//  IDW    2   requester-id width, = clog2(NREQ)
// PORTS
//  clk          in   1           rising-edge clock; the block's only clock
//  reset        in   1           synchronous, active-high reset
//  req_valid    in   NREQ        per-requester request valid
//  req_ready    out  NREQ        per-requester accept (one-hot or zero)
//  req_a        in   NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//  req_b        in   NREQ*WIDTH  operand B, same packing
//  req_sub      in   NREQ        1 = A-B, 0 = A+B
//  rsp_valid    out  1           result valid
//  rsp_ready    in   1           consumer accepts result
//  rsp_id       out  IDW         index of the requester that issued the op
//  rsp_result   out  WIDTH       sum/difference, modulo 2^WIDTH
//  rsp_cout     out  1           carry-out of MSB (subtract: 1 = no borrow)
// BEHAVIOUR
//  Reset (sync, active-high): state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_cout=0, operand regs=0.
//  FSM: IDLE -> EXEC -> RESP -> IDLE.
//   IDLE: req_ready = one-hot grant of the first asserted req_valid at or after rr_ptr (wrapping mod NREQ); combinational.
//    On a grant, capture a, b, sub, id. Set rr_ptr = (grant_idx+1) mod NREQ. Go to EXEC. No valid -> stay, ptr unchanged.
//   EXEC: adder computes op_a + (op_sub ? ~op_b : op_b) + op_sub. Register result/cout/id into rsp_*. Set rsp_valid=1. Go to RESP.
//   RESP: hold every rsp_* stable while rsp_valid & !rsp_ready. On rsp_ready: rsp_valid=0 next cycle. Go to IDLE.
//  req_ready is 0 in EXEC and RESP. A transfer occurs only on req_valid[i] & req_ready[i].
//  Latency: grant in cycle T -> rsp_valid high in T+2. Best-case throughput 1 op per 3 cycles.
//  Requester may drop req_valid before grant; there is no penalty and no grant is issued to it.
//  Arithmetic: carry chain is LSB->MSB; overflow is not flagged; result wraps (0xFFFFFFFF+1 = 0, cout=1).
//  Subtract carry-in is 1. Subtract is two's complement: 0-1 = 0xFFFFFFFF, cout=0.
//  All NREQ valid continuously: grants rotate 0,1,2,3,0,... Each requester waits at most NREQ ops.
//  rsp_ready high in the same cycle rsp_valid rises: accepted that edge; IDLE next cycle.
//  rsp_ready asserted while rsp_valid=0 is ignored.
//  Reset mid-operation: in-flight op is discarded with no response. rr_ptr returns to 0.
//  No X on outputs after reset; rsp_result/rsp_id/rsp_cout keep the last value while rsp_valid=0.
// STRUCTURE
//  Shared package adder_share_pkg holds:
//   - FSM state localparams: IDLE=2'd0, EXEC=2'd1, RESP=2'd2
//   - WIDTH/NREQ defaults
//   - OP_ADD=1'b0, OP_SUB=1'b1
//  One sub-module: rr_arbiter (NREQ req, ptr in -> one-hot grant, idx, any). Purely combinational.
//  Adder datapath: the team's existing 32-bit ripple-carry adder, extended with a cin input and cout output.
// TESTING
//  1. Reset held 3 cycles with req_valid=4'hF -> req_ready=0, rsp_valid=0, all rsp_* = 0 throughout.
//  2. Req0 a=5, b=7, add; rsp_ready=1 -> grant cycle T; rsp_valid at T+2; result=12, cout=0, id=0.
//  3. Req2 a=0xFFFFFFFF, b=1, add -> result=0, cout=1. Req1 a=0, b=1, sub -> 0xFFFFFFFF, cout=0.
//  4. req_valid=4'hF held, rsp_ready=1 -> grant order 0,1,2,3,0; one grant every 3 cycles.
//  5. rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, req_ready=0. Release -> next grant 1 cycle later.
//  6. Reset asserted in EXEC -> no response emitted. Next request from req3 is granted first (ptr=0 scan).

Source files
------------

// File: rtl/adder_share_pkg.sv
// Shared definitions for the shared ripple-carry add/subtract controller:
// FSM encoding, default sizes, operation codes and a wrap-around index helper.
package adder_share_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int NREQ_DEF  = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Successor of idx in a ring of n requesters; n need not be a power of two.
  function automatic int next_idx(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/adder_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// after ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  // NOTE: every output gets a default before the search loop so that no path
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      int j;
      j = (int'(ptr) + off) % NREQ;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// One registered ripple-carry add/subtract datapath shared by NREQ requesters
// under round-robin arbitration; one operation in flight, valid/ready on both sides.
module adder_share_ctrl
  import adder_share_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = NREQ_DEF,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_sub,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_cout
);

  state_t            state, state_nxt;
  logic [IDW-1:0]    rr_ptr;
  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    grant_idx;
  logic              grant_any;
  logic              capture;
  logic              load_rsp;

  logic [WIDTH-1:0]  op_a, op_b;
  logic              op_sub;
  logic [IDW-1:0]    op_id;
  logic [WIDTH-1:0]  sum;
  logic              cout;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // Grants are offered only in IDLE and never while reset is asserted.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    capture   = 1'b0;
    load_rsp  = 1'b0;
    case (state)
      IDLE: begin
        if (!reset && grant_any) begin
          req_ready = grant;
          capture   = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        load_rsp  = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the carry ripples through a loop-local variable, so blocking
  // assignments are required here; each bit must see the previous bit's carry.
  always_comb begin : ripple
    logic             c;
    logic [WIDTH-1:0] b_eff;
    b_eff = (op_sub == OP_SUB) ? ~op_b : op_b;
    c     = op_sub;
    sum   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = op_a[i] ^ b_eff[i] ^ c;
      c      = (op_a[i] & b_eff[i]) | (c & (op_a[i] ^ b_eff[i]));
    end
    cout = c;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_sub     <= OP_ADD;
      op_id      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_cout   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        op_a   <= req_a[int'(grant_idx)*WIDTH +: WIDTH];
        op_b   <= req_b[int'(grant_idx)*WIDTH +: WIDTH];
        op_sub <= req_sub[grant_idx];
        op_id  <= grant_idx;
        rr_ptr <= IDW'(next_idx(int'(grant_idx), NREQ));
      end
      if (load_rsp) begin
        rsp_valid  <= 1'b1;
        rsp_id     <= op_id;
        rsp_result <= sum;
        rsp_cout   <= cout;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
